// File: rtl/tlb_refill.sv
// tlb_refill: fully associative TLB with combinational lookup and a miss FSM.
// A miss issues one page-walk request and stalls the requester until the
// translation is installed. Replacement takes the lowest invalid entry first,
// then round-robin. A flush clears all entries; a walk in flight when the
// flush arrives completes, but its response is discarded.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   req_valid, req_vpage        lookup request and virtual page
//   flush                       invalidate all entries
//   hit, ppage_out, stall       combinational lookup result and requester stall
//   walk_req_valid, walk_vpage  registered page-walk request
//   walk_resp_valid, walk_ppage page-walk response, one-cycle pulse
//   hit_count, miss_count       saturating performance counters
`ifndef TLB_ENTRIES
`define TLB_ENTRIES 4
`endif
`ifndef PAGE_WIDTH
`define PAGE_WIDTH 20
`endif

module tlb_refill #(
    parameter int unsigned N         = `TLB_ENTRIES,
    parameter int unsigned WIDTH     = `PAGE_WIDTH,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    input  logic [WIDTH-1:0]     req_vpage,
    input  logic                 flush,
    output logic                 hit,
    output logic [WIDTH-1:0]     ppage_out,
    output logic                 stall,
    output logic                 walk_req_valid,
    output logic [WIDTH-1:0]     walk_vpage,
    input  logic                 walk_resp_valid,
    input  logic [WIDTH-1:0]     walk_ppage,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count
);

    localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WALK = 1'b1;

    logic [N-1:0]           valid_q, valid_d;
    logic [WIDTH-1:0]       vpage_q [N];
    logic [WIDTH-1:0]       vpage_d [N];
    logic [WIDTH-1:0]       ppage_q [N];
    logic [WIDTH-1:0]       ppage_d [N];
    logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [0:0]             state_q, state_d;
    logic                   kill_q, kill_d;
    logic                   walk_req_valid_q, walk_req_valid_d;
    logic [WIDTH-1:0]       walk_vpage_q, walk_vpage_d;
    logic [CNT_WIDTH-1:0]   hit_count_q, hit_count_d;
    logic [CNT_WIDTH-1:0]   miss_count_q, miss_count_d;

    logic                   match_any;
    logic [WIDTH-1:0]       match_ppage;
    logic [PTR_W-1:0]       victim;
    logic                   have_invalid;

    // Lookup: at most one entry matches, so OR-ing the matching ppages selects it.
    always_comb begin
        match_any   = 1'b0;
        match_ppage = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (valid_q[i] && (vpage_q[i] == req_vpage)) begin
                match_any   = 1'b1;
                match_ppage = match_ppage | ppage_q[i];
            end
        end
        hit       = req_valid & match_any;
        ppage_out = hit ? match_ppage : '0;
        stall     = (req_valid & ~match_any) | (state_q == ST_WALK);
    end

    // Victim: lowest-index invalid entry, else the round-robin pointer.
    always_comb begin
        victim       = rr_ptr_q;
        have_invalid = 1'b0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                victim       = PTR_W'(i);
                have_invalid = 1'b1;
            end
        end
    end

    // Next-state, fill and counter logic.
    always_comb begin
        state_d          = state_q;
        kill_d           = kill_q;
        walk_req_valid_d = walk_req_valid_q;
        walk_vpage_d     = walk_vpage_q;
        valid_d          = valid_q;
        vpage_d          = vpage_q;
        ppage_d          = ppage_q;
        rr_ptr_d         = rr_ptr_q;
        hit_count_d      = hit_count_q;
        miss_count_d     = miss_count_q;

        if (hit && (hit_count_q != '1)) begin
            hit_count_d = hit_count_q + CNT_WIDTH'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (req_valid && !match_any && !flush) begin
                    state_d          = ST_WALK;
                    walk_req_valid_d = 1'b1;
                    walk_vpage_d     = req_vpage;
                    if (miss_count_q != '1) begin
                        miss_count_d = miss_count_q + CNT_WIDTH'(1);
                    end
                end
            end
            ST_WALK: begin
                if (walk_resp_valid) begin
                    state_d          = ST_IDLE;
                    walk_req_valid_d = 1'b0;
                    kill_d           = 1'b0;
                    // A flush now or earlier in this walk discards the response.
                    if (!kill_q && !flush) begin
                        valid_d[victim] = 1'b1;
                        vpage_d[victim] = walk_vpage_q;
                        ppage_d[victim] = walk_ppage;
                        if (!have_invalid) begin
                            rr_ptr_d = (rr_ptr_q == PTR_W'(N - 1)) ? '0
                                                                  : rr_ptr_q + PTR_W'(1);
                        end
                    end
                end else if (flush) begin
                    kill_d = 1'b1;
                end
            end
            default: begin
                state_d          = ST_IDLE;
                walk_req_valid_d = 1'b0;
            end
        endcase

        if (flush) begin
            valid_d = '0;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q          <= '0;
            rr_ptr_q         <= '0;
            state_q          <= ST_IDLE;
            kill_q           <= 1'b0;
            walk_req_valid_q <= 1'b0;
            walk_vpage_q     <= '0;
            hit_count_q      <= '0;
            miss_count_q     <= '0;
            for (int i = 0; i < int'(N); i++) begin
                vpage_q[i] <= '0;
                ppage_q[i] <= '0;
            end
        end else begin
            valid_q          <= valid_d;
            rr_ptr_q         <= rr_ptr_d;
            state_q          <= state_d;
            kill_q           <= kill_d;
            walk_req_valid_q <= walk_req_valid_d;
            walk_vpage_q     <= walk_vpage_d;
            hit_count_q      <= hit_count_d;
            miss_count_q     <= miss_count_d;
            for (int i = 0; i < int'(N); i++) begin
                vpage_q[i] <= vpage_d[i];
                ppage_q[i] <= ppage_d[i];
            end
        end
    end

    assign walk_req_valid = walk_req_valid_q;
    assign walk_vpage     = walk_vpage_q;
    assign hit_count      = hit_count_q;
    assign miss_count     = miss_count_q;

endmodule

// File: tb/tb_tlb_refill.sv
// tb_tlb_refill: scenario tasks for tlb_refill; expected translations are
// queued when a request is driven and popped when the DUT reports a hit.
// A second instance with 4-bit counters shares all inputs for saturation.
`timescale 1ns/1ps

module tb_tlb_refill;

    localparam int unsigned W = 20;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         req_valid = 1'b0;
    logic [W-1:0] req_vpage = '0;
    logic         flush = 1'b0;
    logic         walk_resp_valid = 1'b0;
    logic [W-1:0] walk_ppage = '0;

    logic         hit, stall, walk_req_valid;
    logic [W-1:0] ppage_out, walk_vpage;
    logic [15:0]  hit_count, miss_count;

    logic         hit4, stall4, wrv4;
    logic [W-1:0] ppage4, wvp4;
    logic [3:0]   hc4, mc4;

    int total = 0;
    int bad = 0;
    int exp_hit = 0;
    int exp_miss = 0;
    logic [W-1:0] exp_q [$];

    logic         prev_rv = 1'b0;
    logic         prev_st = 1'b0;
    logic [W-1:0] prev_vp = '0;

    always #5 clk = ~clk;

    tlb_refill #(.N(4), .WIDTH(W), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_vpage(req_vpage),
        .flush(flush), .hit(hit), .ppage_out(ppage_out), .stall(stall),
        .walk_req_valid(walk_req_valid), .walk_vpage(walk_vpage),
        .walk_resp_valid(walk_resp_valid), .walk_ppage(walk_ppage),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    tlb_refill #(.N(4), .WIDTH(W), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_vpage(req_vpage),
        .flush(flush), .hit(hit4), .ppage_out(ppage4), .stall(stall4),
        .walk_req_valid(wrv4), .walk_vpage(wvp4),
        .walk_resp_valid(walk_resp_valid), .walk_ppage(walk_ppage),
        .hit_count(hc4), .miss_count(mc4)
    );

    // Advance one cycle; flags a requester that changes vpage while stalled.
    task automatic tick();
        @(negedge clk);
        if (!reset && prev_rv && prev_st && req_valid && (req_vpage !== prev_vp)) begin
            bad++;
            $display("FAIL protocol: vpage changed under stall got=%h held=%h", req_vpage, prev_vp);
        end
        prev_rv = req_valid;
        prev_st = stall;
        prev_vp = req_vpage;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = 1'b0; flush = 1'b0; walk_resp_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_hit = 0;
        exp_miss = 0;
        #1;
    endtask

    // One lookup; on a miss the walk is answered after lat cycles with pp.
    task automatic access(input logic [W-1:0] vp, input logic [W-1:0] pp,
                          input bit miss, input int lat);
        logic [W-1:0] want;
        req_valid = 1'b1; req_vpage = vp;
        exp_q.push_back(pp);
        #1;
        if (miss) begin
            total++;
            if (hit !== 1'b0 || stall !== 1'b1) begin
                bad++;
                $display("FAIL miss_detect vp=%h got hit=%b stall=%b want hit=0 stall=1", vp, hit, stall);
            end
            tick();
            exp_miss++;
            total++;
            if (walk_req_valid !== 1'b1 || walk_vpage !== vp) begin
                bad++;
                $display("FAIL walk_issue got valid=%b vpage=%h want valid=1 vpage=%h", walk_req_valid, walk_vpage, vp);
            end
            for (int c = 1; c < lat; c++) tick();
            walk_resp_valid = 1'b1; walk_ppage = pp;
            tick();
            walk_resp_valid = 1'b0; walk_ppage = '0;
            #1;
        end
        total++;
        if (hit !== 1'b1 || stall !== 1'b0) begin
            bad++;
            $display("FAIL hit vp=%h got hit=%b stall=%b want hit=1 stall=0", vp, hit, stall);
        end
        want = exp_q.pop_front();
        total++;
        if (ppage_out !== want) begin
            bad++;
            $display("FAIL ppage vp=%h got=%h want=%h", vp, ppage_out, want);
        end
        exp_hit++;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic check_counters(input string name);
        total++;
        if (hit_count !== 16'(exp_hit) || miss_count !== 16'(exp_miss)) begin
            bad++;
            $display("FAIL %s counters got hit=%0d miss=%0d want hit=%0d miss=%0d",
                     name, hit_count, miss_count, exp_hit, exp_miss);
        end
    endtask

    task automatic test_reset();
        do_reset();
        tick();
        total++;
        if (walk_req_valid !== 1'b0 || walk_vpage !== '0 || hit_count !== '0 || miss_count !== '0) begin
            bad++;
            $display("FAIL reset_regs got wrv=%b wvp=%h hc=%0d mc=%0d want all 0", walk_req_valid, walk_vpage, hit_count, miss_count);
        end
        total++;
        if (hit !== 1'b0 || ppage_out !== '0 || stall !== 1'b0) begin
            bad++;
            $display("FAIL reset_lookup got hit=%b pp=%h stall=%b want 0 0 0", hit, ppage_out, stall);
        end
        // Miss together with flush: stalls but must not start a walk.
        req_valid = 1'b1; req_vpage = 20'h00123; flush = 1'b1;
        #1;
        total++;
        if (stall !== 1'b1 || hit !== 1'b0) begin
            bad++;
            $display("FAIL reset_stall got stall=%b hit=%b want stall=1 hit=0", stall, hit);
        end
        tick();
        flush = 1'b0; req_valid = 1'b0;
        #1;
        total++;
        if (walk_req_valid !== 1'b0 || miss_count !== '0) begin
            bad++;
            $display("FAIL flush_miss_no_walk got wrv=%b mc=%0d want 0 0", walk_req_valid, miss_count);
        end
    endtask

    task automatic test_first_miss();
        do_reset();
        access(20'h00010, 20'h0ABCD, 1'b1, 3);
        check_counters("first_miss");
    endtask

    task automatic test_replacement();
        logic [W-1:0] vps [16];
        bit           mis [16];
        vps = '{20'd1, 20'd2, 20'd3, 20'd4, 20'd5, 20'd6, 20'd3, 20'd4,
                20'd5, 20'd6, 20'd1, 20'd3, 20'd4, 20'd6, 20'd1, 20'd3};
        mis = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
                1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        do_reset();
        for (int i = 0; i < 16; i++) begin
            access(vps[i], vps[i] + 20'h100, mis[i], 1 + (i % 2));
        end
        check_counters("replacement");
    endtask

    task automatic test_flush_walk();
        do_reset();
        access(20'h00021, 20'h00321, 1'b1, 2);
        req_valid = 1'b1; req_vpage = 20'h00020;
        #1;
        tick();
        exp_miss++;
        flush = 1'b1;
        tick();
        flush = 1'b0; walk_resp_valid = 1'b1; walk_ppage = 20'h00999;
        tick();
        walk_resp_valid = 1'b0; walk_ppage = '0;
        #1;
        total++;
        if (walk_req_valid !== 1'b0 || stall !== 1'b1 || hit !== 1'b0) begin
            bad++;
            $display("FAIL flush_walk_drop got wrv=%b stall=%b hit=%b want 0 1 0", walk_req_valid, stall, hit);
        end
        tick();
        exp_miss++;
        total++;
        if (walk_req_valid !== 1'b1 || walk_vpage !== 20'h00020 || miss_count !== 16'(exp_miss)) begin
            bad++;
            $display("FAIL flush_rewalk got wrv=%b wvp=%h mc=%0d want 1 00020 %0d", walk_req_valid, walk_vpage, miss_count, exp_miss);
        end
        exp_q.push_back(20'h00520);
        walk_resp_valid = 1'b1; walk_ppage = 20'h00520;
        tick();
        walk_resp_valid = 1'b0;
        #1;
        total++;
        if (hit !== 1'b1 || ppage_out !== exp_q.pop_front()) begin
            bad++;
            $display("FAIL flush_refill got hit=%b pp=%h want hit=1 pp=00520", hit, ppage_out);
        end
        exp_hit++;
        tick();
        req_valid = 1'b0;
        access(20'h00021, 20'h00322, 1'b1, 1);
        check_counters("flush_walk");
    endtask

    task automatic test_flush_coincident();
        do_reset();
        req_valid = 1'b1; req_vpage = 20'h00030;
        #1;
        tick();
        exp_miss++;
        tick();
        walk_resp_valid = 1'b1; walk_ppage = 20'h00630; flush = 1'b1;
        tick();
        walk_resp_valid = 1'b0; flush = 1'b0;
        #1;
        total++;
        if (walk_req_valid !== 1'b0 || hit !== 1'b0 || stall !== 1'b1) begin
            bad++;
            $display("FAIL coincident_drop got wrv=%b hit=%b stall=%b want 0 0 1", walk_req_valid, hit, stall);
        end
        req_valid = 1'b0;
        tick();
        access(20'h00030, 20'h00631, 1'b1, 2);
        check_counters("coincident");
    endtask

    task automatic test_reset_mid_walk();
        do_reset();
        access(20'h00060, 20'h00660, 1'b1, 1);
        req_valid = 1'b1; req_vpage = 20'h00050;
        #1;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; req_valid = 1'b0;
        #1;
        total++;
        if (walk_req_valid !== 1'b0 || hit_count !== '0 || miss_count !== '0 || stall !== 1'b0) begin
            bad++;
            $display("FAIL reset_walk got wrv=%b hc=%0d mc=%0d stall=%b want 0 0 0 0", walk_req_valid, hit_count, miss_count, stall);
        end
        walk_resp_valid = 1'b1; walk_ppage = 20'h00777;
        tick();
        walk_resp_valid = 1'b0;
        req_valid = 1'b1; req_vpage = 20'h00050; flush = 1'b1;
        #1;
        total++;
        if (walk_req_valid !== 1'b0 || hit !== 1'b0 || ppage_out !== '0 || miss_count !== '0) begin
            bad++;
            $display("FAIL stray_resp got wrv=%b hit=%b pp=%h mc=%0d want 0 0 0 0", walk_req_valid, hit, ppage_out, miss_count);
        end
        tick();
        flush = 1'b0; req_valid = 1'b0;
    endtask

    task automatic test_saturation();
        do_reset();
        access(20'h00040, 20'h00440, 1'b1, 1);
        req_valid = 1'b1; req_vpage = 20'h00040;
        repeat (19) tick();
        exp_hit += 19;
        req_valid = 1'b0;
        #1;
        total++;
        if (hc4 !== 4'd15 || mc4 !== 4'd1 || wrv4 !== 1'b0 || wvp4 !== 20'h00040) begin
            bad++;
            $display("FAIL sat_20 got hc=%0d mc=%0d wrv=%b wvp=%h want 15 1 0 00040", hc4, mc4, wrv4, wvp4);
        end
        check_counters("sat_wide");
        req_valid = 1'b1;
        #1;
        total++;
        if (hit4 !== 1'b1 || stall4 !== 1'b0 || ppage4 !== 20'h00440) begin
            bad++;
            $display("FAIL sat_lookup got hit=%b stall=%b pp=%h want 1 0 00440", hit4, stall4, ppage4);
        end
        repeat (3) tick();
        exp_hit += 3;
        req_valid = 1'b0;
        #1;
        total++;
        if (hc4 !== 4'd15) begin
            bad++;
            $display("FAIL sat_hold got hc=%0d want 15", hc4);
        end
        check_counters("sat_wide_more");
    endtask

    initial begin
        test_reset();
        test_first_miss();
        test_replacement();
        test_flush_walk();
        test_flush_coincident();
        test_reset_mid_walk();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
